// File: rtl/nrzi_rx_decoder.sv
// NRZI receive decoder: destuffs, hunts for SYNC and assembles bytes LSB-first.
// Optional byte counter port/logic enabled by defining NRZI_RX_BYTE_COUNT_EN.
module nrzi_rx_decoder #(
    parameter int         STUFF_LEN = 6,
    parameter logic [7:0] SYNC      = 8'h80
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                bit_en,
    input  logic                                line_in,
    output logic [7:0]                          data_out,
    output logic                                data_valid,
    output logic                                frame_active,
    output logic                                frame_done,
    output logic                                frame_err,
`ifdef NRZI_RX_BYTE_COUNT_EN
    output logic [7:0]                          byte_count,
`endif
    output logic                                dbg_state,
    output logic [$clog2(STUFF_LEN + 2)-1:0]    dbg_ones_cnt
);

    localparam int OW = $clog2(STUFF_LEN + 2);
    localparam logic [OW-1:0] ONES_STUFF = OW'(STUFF_LEN);
    localparam logic [OW-1:0] ONES_SAT   = OW'(STUFF_LEN + 1);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          prev_line_q, prev_line_d;
    logic [7:0]    sync_q, sync_d;
    logic [7:0]    byte_q, byte_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [OW-1:0] ones_cnt_q, ones_cnt_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          data_valid_q, data_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    byte_count_q, byte_count_d;

    logic          dec_bit;
    logic [OW-1:0] ones_next;

    // No transition on the line decodes as 1, a transition as 0.
    assign dec_bit   = (line_in == prev_line_q);
    assign ones_next = dec_bit ? ((ones_cnt_q == ONES_SAT) ? ONES_SAT : ones_cnt_q + 1'b1)
                               : '0;

    always_comb begin
        state_d      = state_q;
        prev_line_d  = prev_line_q;
        sync_d       = sync_q;
        byte_d       = byte_q;
        bit_cnt_d    = bit_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        data_out_d   = data_out_q;
        byte_count_d = byte_count_q;
        data_valid_d = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        if (bit_en) begin
            prev_line_d = line_in;
            if (state_q == ST_HUNT) begin
                sync_d     = {dec_bit, sync_q[7:1]};
                ones_cnt_d = ones_next;
                if (sync_d == SYNC) begin
                    state_d      = ST_DATA;
                    bit_cnt_d    = 3'd0;
                    ones_cnt_d   = '0;
                    byte_d       = 8'd0;
                    byte_count_d = 8'd0;
                end
            end else begin
                if (ones_cnt_q == ONES_STUFF && !dec_bit) begin
                    ones_cnt_d = '0;
                end else if (ones_cnt_q == ONES_STUFF && dec_bit) begin
                    // A run of STUFF_LEN+1 ones can only be end-of-frame.
                    frame_done_d = 1'b1;
                    frame_err_d  = (bit_cnt_q != 3'd0);
                    state_d      = ST_HUNT;
                    sync_d       = 8'd0;
                    ones_cnt_d   = '0;
                end else begin
                    byte_d     = {dec_bit, byte_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    ones_cnt_d = ones_next;
                    if (bit_cnt_q == 3'd7) begin
                        data_out_d   = byte_d;
                        data_valid_d = 1'b1;
                        if (byte_count_q != 8'hFF) begin
                            byte_count_d = byte_count_q + 8'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            prev_line_q  <= 1'b1;
            sync_q       <= 8'd0;
            byte_q       <= 8'd0;
            bit_cnt_q    <= 3'd0;
            ones_cnt_q   <= '0;
            data_out_q   <= 8'd0;
            data_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            byte_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            prev_line_q  <= prev_line_d;
            sync_q       <= sync_d;
            byte_q       <= byte_d;
            bit_cnt_q    <= bit_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign frame_active = (state_q == ST_DATA);
    assign frame_done   = frame_done_q;
    assign frame_err    = frame_err_q;
    assign dbg_state    = state_q[0];
    assign dbg_ones_cnt = ones_cnt_q;
`ifdef NRZI_RX_BYTE_COUNT_EN
    assign byte_count   = byte_count_q;
`else
    logic unused_byte_count;
    assign unused_byte_count = ^byte_count_q;
`endif

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Directed bench for nrzi_rx_decoder: bits are encoded to NRZI by the bench.
// Builds with or without NRZI_RX_BYTE_COUNT_EN.
module tb_nrzi_rx_decoder;

    logic       clk;
    logic       rst;
    logic       bit_en;
    logic       line_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_active;
    logic       frame_done;
    logic       frame_err;
`ifdef NRZI_RX_BYTE_COUNT_EN
    logic [7:0] byte_count;
`endif
    logic       dbg_state;
    logic [2:0] dbg_ones_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int dv_count = 0;
    int done_count = 0;
    int err_count  = 0;
    logic cur_line;

    nrzi_rx_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .bit_en       (bit_en),
        .line_in      (line_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
`ifdef NRZI_RX_BYTE_COUNT_EN
        .byte_count   (byte_count),
`endif
        .dbg_state    (dbg_state),
        .dbg_ones_cnt (dbg_ones_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: each output pulse is high across exactly one falling edge.
    always @(negedge clk) begin
        if (data_valid === 1'b1) dv_count++;
        if (frame_done === 1'b1) done_count++;
        if (frame_err === 1'b1)  err_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic d);
        @(negedge clk);
        cur_line = d ? cur_line : ~cur_line;
        line_in  = cur_line;
        bit_en   = 1'b1;
        @(negedge clk);
        bit_en   = 1'b0;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_ones(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst    = 1'b1;
        bit_en = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            line_in = ~line_in;
            @(negedge clk);
        end
        rst      = 1'b0;
        bit_en   = 1'b0;
        cur_line = 1'b1;
        line_in  = 1'b1;
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        bit_en   = 1'b0;
        line_in  = 1'b1;
        cur_line = 1'b1;

        // Reset with the line toggling and bit_en high.
        do_reset(2);
        chk("rst_data_out", 32'(data_out), 32'h00);
        chk("rst_data_valid", 32'(data_valid), 32'h0);
        chk("rst_frame_active", 32'(frame_active), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'h0);
`ifdef NRZI_RX_BYTE_COUNT_EN
        chk("rst_byte_count", 32'(byte_count), 32'h0);
`endif

        // Payload without a preceding sync never completes a byte.
        send_byte(8'hA5);
        chk("nosync_dv_count", 32'(dv_count), 32'd0);
        do_reset(1);

        // Frame 1: sync, A5, FF with a stuffed bit, FC, then end.
        send_byte(8'h80);
        chk("sync_frame_active", 32'(frame_active), 32'h1);
        chk("sync_state", 32'(dbg_state), 32'h1);
        chk("sync_ones_cleared", 32'(dbg_ones_cnt), 32'd0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        chk("a5_no_early_dv", 32'(dv_count), 32'd0);
        send_bit(1'b1);
        chk("a5_data_valid", 32'(data_valid), 32'h1);
        chk("a5_data_out", 32'(data_out), 32'hA5);
        @(negedge clk); #1;
        chk("a5_dv_one_clock", 32'(data_valid), 32'h0);
        chk("a5_data_out_hold", 32'(data_out), 32'hA5);
        chk("a5_ones_cnt", 32'(dbg_ones_cnt), 32'd1);

        // Ones count carries from A5: five more 1s reach the stuff threshold.
        send_ones(5);
        chk("f1_ones_at_stuff", 32'(dbg_ones_cnt), 32'd6);
        send_bit(1'b0);
        chk("f1_stuff_cleared", 32'(dbg_ones_cnt), 32'd0);
        chk("f1_stuff_no_dv", 32'(dv_count), 32'd1);
        send_ones(3);
        chk("f1_ff_dv_count", 32'(dv_count), 32'd2);
        chk("f1_ff_data_out", 32'(data_out), 32'hFF);
        chk("f1_ff_ones", 32'(dbg_ones_cnt), 32'd3);

        send_byte(8'hFC);
        chk("f1_fc_data_out", 32'(data_out), 32'hFC);
        chk("f1_fc_ones", 32'(dbg_ones_cnt), 32'd6);
        send_bit(1'b1);
        chk("f1_end_done", 32'(frame_done), 32'h1);
        chk("f1_end_err", 32'(frame_err), 32'h0);
        chk("f1_end_active", 32'(frame_active), 32'h0);
        chk("f1_end_state", 32'(dbg_state), 32'h0);
`ifdef NRZI_RX_BYTE_COUNT_EN
        chk("f1_byte_count", 32'(byte_count), 32'd3);
`endif
        @(negedge clk); #1;
        chk("f1_done_one_clock", 32'(frame_done), 32'h0);
        chk("f1_dv_total", 32'(dv_count), 32'd3);
        chk("f1_data_out_hold", 32'(data_out), 32'hFC);

        // Frame 2: sync, line gating, stuffing, then abort mid-byte.
        send_byte(8'h80);
        chk("f2_sync_active", 32'(frame_active), 32'h1);
`ifdef NRZI_RX_BYTE_COUNT_EN
        chk("f2_byte_count_clr", 32'(byte_count), 32'd0);
`endif
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            line_in = ~line_in;
        end
        @(negedge clk);
        line_in = cur_line;
        #1;
        chk("gate_active", 32'(frame_active), 32'h1);
        chk("gate_state", 32'(dbg_state), 32'h1);
        chk("gate_ones", 32'(dbg_ones_cnt), 32'd0);
        chk("gate_data_out", 32'(data_out), 32'hFC);
        chk("gate_dv_count", 32'(dv_count), 32'd3);

        send_ones(6);
        send_bit(1'b0);
        send_ones(2);
        chk("f2_ff_data_out", 32'(data_out), 32'hFF);
        chk("f2_ff_dv_count", 32'(dv_count), 32'd4);
        chk("f2_ones_after", 32'(dbg_ones_cnt), 32'd2);
`ifdef NRZI_RX_BYTE_COUNT_EN
        chk("f2_byte_count", 32'(byte_count), 32'd1);
`endif
        send_ones(4);
        send_bit(1'b1);
        chk("f2_abort_done", 32'(frame_done), 32'h1);
        chk("f2_abort_err", 32'(frame_err), 32'h1);
        chk("f2_abort_active", 32'(frame_active), 32'h0);
        @(negedge clk); #1;
        chk("f2_err_one_clock", 32'(frame_err), 32'h0);
        chk("f2_dv_count", 32'(dv_count), 32'd4);
        chk("f2_done_count", 32'(done_count), 32'd2);
        chk("f2_err_count", 32'(err_count), 32'd1);

        // Frame 3: reset mid-byte; no frame_done may appear.
        send_byte(8'h80);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        chk("f3_active", 32'(frame_active), 32'h1);
        do_reset(1);
        chk("f3_rst_active", 32'(frame_active), 32'h0);
        chk("f3_rst_state", 32'(dbg_state), 32'h0);
        chk("f3_rst_data_out", 32'(data_out), 32'h00);
        chk("f3_rst_ones", 32'(dbg_ones_cnt), 32'd0);
`ifdef NRZI_RX_BYTE_COUNT_EN
        chk("f3_rst_byte_count", 32'(byte_count), 32'd0);
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("f3_done_count", 32'(done_count), 32'd2);
        chk("f3_err_count", 32'(err_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
